icache_refill: RTL and testbench

- Refill engine directly upstream of the instruction cache.
- On a cache miss it wins the shared byte-wide RAM bus through a request/grant handshake and streams in one aligned block of BLOCK_SIZE bytes.
- It assembles those bytes into one line and presents the line to the cache with a single-cycle valid strobe plus the block address.
- Sits between the instruction cache (miss, fetch address) and the memory arbiter/RAM port.

---
 rtl/icache_refill_pkg.sv | 16 +
 rtl/icache_refill_if.sv | 31 +++
 rtl/icache_refill_assembler.sv | 19 +
 rtl/icache_refill.sv | 103 ++++++++++
 tb/tb_icache_refill.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared types and constants for the instruction-cache refill engine
package icache_refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } refill_state_t;

    localparam int DEF_BLOCK_WIDTH = 4;

    // Cycles between driving a RAM address and its byte appearing on memDataIn.
    localparam int RAM_LATENCY = 1;

endpackage

// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - cache-side and RAM-side signals of the refill engine
interface icache_refill_if import icache_refill_pkg::*; #(
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) ();
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;

    logic                      missIn;
    logic [31:0]               missAddrIn;
    logic                      flushIn;
    logic                      memReqOut;
    logic                      memGrantIn;
    logic [31:0]               memAddrOut;
    logic                      memWrOut;
    logic [7:0]                memDataIn;
    logic                      blockValidOut;
    logic [31-BLOCK_WIDTH:0]   blockAddrOut;
    logic [BLOCK_SIZE*8-1:0]   blockDataOut;
    logic                      busyOut;

    modport slave (
        input  missIn, missAddrIn, flushIn, memGrantIn, memDataIn,
        output memReqOut, memAddrOut, memWrOut,
               blockValidOut, blockAddrOut, blockDataOut, busyOut
    );

    modport master (
        output missIn, missAddrIn, flushIn, memGrantIn, memDataIn,
        input  memReqOut, memAddrOut, memWrOut,
               blockValidOut, blockAddrOut, blockDataOut, busyOut
    );
endinterface

// File: rtl/icache_refill_assembler.sv
// rtl/icache_refill_assembler.sv - byte-indexed writes of RAM data into the refill line register
module icache_refill_assembler import icache_refill_pkg::*; #(
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
    input  logic                          clkIn,
    input  logic                          resetIn,
    input  logic                          captureEn,
    input  logic [BLOCK_WIDTH-1:0]        byteIdx,
    input  logic [7:0]                    byteIn,
    output logic [(2**BLOCK_WIDTH)*8-1:0] lineOut
);
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            lineOut <= '0;
        end else if (captureEn) begin
            lineOut[{byteIdx, 3'b000} +: 8] <= byteIn;
        end
    end
endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - wins the RAM bus on a miss and streams one aligned block into a cache line
module icache_refill import icache_refill_pkg::*; #(
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
    input  logic            clkIn,
    input  logic            resetIn,
    icache_refill_if.slave  bus
);
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
    localparam int CNT_W      = BLOCK_WIDTH + 1;
    localparam int BASE_W     = 32 - BLOCK_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE);

    refill_state_t           state, stateNext;
    logic [CNT_W-1:0]        cnt, cntNext;
    logic [BASE_W-1:0]       base, baseNext;
    logic                    captureEn;
    logic [BLOCK_WIDTH-1:0]  captureIdx;
    logic [BLOCK_SIZE*8-1:0] line;

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            base  <= baseNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        baseNext  = base;
        unique case (state)
            IDLE: begin
                if (bus.missIn && !bus.flushIn) begin
                    baseNext  = BASE_W'(bus.missAddrIn >> BLOCK_WIDTH);
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (bus.flushIn) begin
                    stateNext = IDLE;
                end else if (bus.memGrantIn) begin
                    stateNext = FETCH;
                    cntNext   = '0;
                end
            end
            FETCH: begin
                // Partial lines are simply never strobed; the line register is left as is.
                if (bus.flushIn) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt == CNT_LAST) begin
                    stateNext = DONE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The byte arriving now was addressed RAM_LATENCY cycles ago.
    assign captureEn  = (state == FETCH) && (cnt != '0);
    assign captureIdx = cnt[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(RAM_LATENCY);

    icache_refill_assembler #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_assembler (
        .clkIn     (clkIn),
        .resetIn   (resetIn),
        .captureEn (captureEn),
        .byteIdx   (captureIdx),
        .byteIn    (bus.memDataIn),
        .lineOut   (line)
    );

    always_comb begin
        bus.memAddrOut = '0;
        if (state == FETCH) begin
            bus.memAddrOut = (cnt == CNT_LAST) ? {base, {BLOCK_WIDTH{1'b1}}}
                                               : {base, cnt[BLOCK_WIDTH-1:0]};
        end
    end

    assign bus.memReqOut     = (state == REQ) || (state == FETCH);
    assign bus.memWrOut      = 1'b0;
    assign bus.blockValidOut = (state == DONE) && !bus.flushIn;
    assign bus.blockAddrOut  = base;
    assign bus.blockDataOut  = line;
    assign bus.busyOut       = (state != IDLE);

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - randomized and directed checks of icache_refill against a timeline model
module tb_icache_refill;
    localparam int BW = 4;
    localparam int BS = 16;

    logic clkIn = 1'b0;
    logic resetIn = 1'b0;
    always #5 clkIn = ~clkIn;

    icache_refill_if #(.BLOCK_WIDTH(BW)) bus ();

    icache_refill #(.BLOCK_WIDTH(BW)) dut (
        .clkIn   (clkIn),
        .resetIn (resetIn),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    bit started = 0;
    int strobeCount = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM and arbiter models
    logic [7:0] seed = 8'h00;
    int grantDelay = 2;
    int reqAge = 0;

    function automatic logic [7:0] ramByte(input logic [31:0] a);
        return a[7:0] ^ seed;
    endfunction

    always @(posedge clkIn) bus.memDataIn <= ramByte(bus.memAddrOut);
    always @(posedge clkIn) reqAge <= bus.memReqOut ? reqAge + 1 : 0;
    assign bus.memGrantIn = bus.memReqOut && (reqAge >= grantDelay);

    // Timeline model: a refill is pending until granted, then fetches for BS+1 cycles, then strobes.
    int cyc = 0;
    bit mPending;
    int mFetchStart;
    logic [27:0] mBase;

    always @(posedge clkIn) cyc <= cyc + 1;

    always @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            mPending    <= 1'b0;
            mFetchStart <= -1;
            mBase       <= '0;
        end else if (mFetchStart >= 0 && cyc - mFetchStart >= BS + 1) begin
            mFetchStart <= -1;
        end else if (mFetchStart >= 0) begin
            if (bus.flushIn) mFetchStart <= -1;
        end else if (mPending) begin
            if (bus.flushIn) mPending <= 1'b0;
            else if (bus.memGrantIn) begin
                mPending    <= 1'b0;
                mFetchStart <= cyc + 1;
            end
        end else if (bus.missIn && !bus.flushIn) begin
            mPending <= 1'b1;
            mBase    <= bus.missAddrIn[31:4];
        end
    end

    function automatic bit mFetching();
        return mFetchStart >= 0 && (cyc - mFetchStart) <= BS;
    endfunction
    function automatic bit mDone();
        return mFetchStart >= 0 && (cyc - mFetchStart) == BS + 1;
    endfunction
    function automatic logic [31:0] mAddr();
        int k;
        if (!mFetching()) return 32'h0;
        k = cyc - mFetchStart;
        if (k > BS - 1) k = BS - 1;
        return {mBase, 4'h0} + k;
    endfunction
    function automatic logic [127:0] mLine();
        logic [127:0] l;
        for (int i = 0; i < BS; i++) l[8*i +: 8] = ramByte({mBase, 4'h0} + i);
        return l;
    endfunction

    always @(negedge clkIn) begin
        if (started && resetIn) begin
            check("memReq",  bus.memReqOut, mPending || mFetching());
            check("busy",    bus.busyOut, mPending || mFetching() || mDone());
            check("memAddr", bus.memAddrOut, mAddr());
            check("memWr",   bus.memWrOut, 1'b0);
            check("valid",   bus.blockValidOut, mDone() && !bus.flushIn);
            if (mDone() && !bus.flushIn) begin
                check("blockAddr", bus.blockAddrOut, mBase);
                check("blockData", bus.blockDataOut, mLine());
            end
        end
        if (bus.blockValidOut) strobeCount <= strobeCount + 1;
    end

    task automatic checkAllZero(input string tag);
        check({tag, ".memReq"},    bus.memReqOut, 0);
        check({tag, ".memAddr"},   bus.memAddrOut, 0);
        check({tag, ".memWr"},     bus.memWrOut, 0);
        check({tag, ".valid"},     bus.blockValidOut, 0);
        check({tag, ".busy"},      bus.busyOut, 0);
        check({tag, ".blockAddr"}, bus.blockAddrOut, 0);
        check({tag, ".blockData"}, bus.blockDataOut, 0);
    endtask

    task automatic waitAddr(input logic [31:0] a, input string tag);
        int n = 0;
        do begin
            @(negedge clkIn);
            n++;
        end while (bus.memAddrOut !== a && n < 60);
        if (bus.memAddrOut !== a) check({tag, ".timeout"}, 0, 1);
    endtask

    task automatic doRefill(input logic [31:0] a, input int delay, output bit got);
        int n = 0;
        grantDelay = delay;
        @(posedge clkIn) #1;
        bus.missIn = 1'b1;
        bus.missAddrIn = a;
        got = 0;
        while (!got && n < 60) begin
            @(negedge clkIn);
            n++;
            if (bus.blockValidOut) got = 1;
        end
        if (!got) check("refill.timeout", 0, 1);
        @(posedge clkIn) #1;
        bus.missIn = 1'b0;
    endtask

    initial begin
        bit got;
        int sc;
        logic [127:0] lit;
        bus.missIn = 0; bus.missAddrIn = 0; bus.flushIn = 0;
        repeat (3) @(posedge clkIn);
        @(negedge clkIn);
        checkAllZero("reset");
        @(posedge clkIn) #1;
        resetIn = 1'b1;
        started = 1;

        // Basic refill with literal expectations
        seed = 8'h00; grantDelay = 2;
        @(posedge clkIn) #1;
        bus.missIn = 1; bus.missAddrIn = 32'h0000_1234;
        waitAddr(32'h1230, "basic");
        for (int i = 1; i < BS; i++) begin
            @(negedge clkIn);
            check("basic.addrSeq", bus.memAddrOut, 32'h1230 + i);
        end
        @(negedge clkIn);
        check("basic.noEarlyValid", bus.blockValidOut, 0);
        @(negedge clkIn);
        lit = 128'h3F3E3D3C3B3A39383736353433323130;
        check("basic.valid", bus.blockValidOut, 1);
        check("basic.blockAddr", bus.blockAddrOut, 28'h0000123);
        check("basic.blockData", bus.blockDataOut, lit);
        @(posedge clkIn) #1;
        bus.missIn = 0;
        @(negedge clkIn);
        check("basic.oneCycle", bus.blockValidOut, 0);
        check("basic.idle", bus.busyOut, 0);

        // Long grant delay
        seed = 8'h5A;
        sc = strobeCount;
        doRefill(32'h0000_5678, 10, got);
        @(negedge clkIn);
        check("grantDelay.strobes", strobeCount - sc, 1);

        // Flush in fetch at cnt=7, then a clean refill
        sc = strobeCount;
        grantDelay = 1;
        @(posedge clkIn) #1;
        bus.missIn = 1; bus.missAddrIn = 32'h0000_3450;
        waitAddr(32'h3457, "flushFetch");
        #1;
        bus.flushIn = 1; bus.missIn = 0;
        @(posedge clkIn) #1;
        bus.flushIn = 0;
        @(negedge clkIn);
        check("flushFetch.memReq", bus.memReqOut, 0);
        check("flushFetch.busy", bus.busyOut, 0);
        check("flushFetch.strobes", strobeCount - sc, 0);
        doRefill(32'h0000_2000, 1, got);

        // Flush during DONE
        sc = strobeCount;
        grantDelay = 0;
        @(posedge clkIn) #1;
        bus.missIn = 1; bus.missAddrIn = 32'h0000_7770;
        waitAddr(32'h7770, "flushDone");
        repeat (BS) @(negedge clkIn);
        @(posedge clkIn) #1;
        bus.flushIn = 1; bus.missIn = 0;
        @(negedge clkIn);
        check("flushDone.valid", bus.blockValidOut, 0);
        check("flushDone.busy", bus.busyOut, 1);
        @(posedge clkIn) #1;
        bus.flushIn = 0;
        @(negedge clkIn);
        check("flushDone.idle", bus.busyOut, 0);
        check("flushDone.strobes", strobeCount - sc, 0);

        // Asynchronous reset mid-fetch
        grantDelay = 1;
        @(posedge clkIn) #1;
        bus.missIn = 1; bus.missAddrIn = 32'h0000_9990;
        waitAddr(32'h9995, "reset");
        #2;
        resetIn = 0; bus.missIn = 0;
        #1;
        checkAllZero("midReset");
        @(posedge clkIn) #3;
        resetIn = 1;
        sc = strobeCount;
        repeat (10) @(negedge clkIn);
        check("midReset.noStrobe", strobeCount - sc, 0);

        // Back-to-back misses
        grantDelay = 1;
        @(posedge clkIn) #1;
        bus.missIn = 1; bus.missAddrIn = 32'h0000_0100;
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clkIn);
            if (bus.blockValidOut) got = 1;
        end
        check("b2b.first", got, 1);
        check("b2b.firstAddr", bus.blockAddrOut, 28'h10);
        @(posedge clkIn) #1;
        bus.missAddrIn = 32'h0000_0110;
        @(negedge clkIn);
        check("b2b.idleCycle", bus.memReqOut, 0);
        @(negedge clkIn);
        check("b2b.reqNoGap", bus.memReqOut, 1);
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clkIn);
            if (bus.blockValidOut) got = 1;
        end
        check("b2b.second", got, 1);
        check("b2b.secondAddr", bus.blockAddrOut, 28'h11);
        @(posedge clkIn) #1;
        bus.missIn = 0;

        // Randomized refills with occasional flushes
        for (int it = 0; it < 40; it++) begin
            int flushAt;
            bit doFlush;
            bit ended;
            repeat (2) @(posedge clkIn);
            #1;
            seed = 8'($urandom);
            grantDelay = $urandom_range(0, 4);
            doFlush = ($urandom_range(0, 9) < 3);
            flushAt = $urandom_range(0, 24);
            bus.missIn = 1;
            bus.missAddrIn = $urandom;
            ended = 0;
            for (int n = 0; n < 60 && !ended; n++) begin
                @(negedge clkIn);
                if (bus.blockValidOut) begin
                    ended = 1;
                    @(posedge clkIn) #1;
                    bus.missIn = 0;
                end else if (doFlush && n == flushAt) begin
                    ended = 1;
                    #1;
                    bus.flushIn = 1; bus.missIn = 0;
                    @(posedge clkIn) #1;
                    bus.flushIn = 0;
                end
            end
            if (!ended) begin
                check("random.timeout", 0, 1);
                bus.missIn = 0;
            end
        end
        repeat (3) @(negedge clkIn);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
